// File: rtl/emesh_pkg.sv
// Shared constants, field layout and state encoding for the emesh FIFO drain.
// Word layout: [0] reserved, [1] write, [3:2] datamode, [7:4] ctrlmode, then dst/data/src.
package emesh_pkg;

  localparam int DW       = 104;
  localparam int WRITE_BIT = 1;
  localparam int DM_LSB   = 2;
  localparam int CM_LSB   = 4;
  localparam int DST_LSB  = 8;
  localparam int DATA_LSB = 40;
  localparam int SRC_LSB  = 72;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] data;
    logic [31:0] srcaddr;
  } emesh_t;

endpackage

// File: rtl/emesh_fifo_drain_if.sv
// FIFO read side plus emesh output bus of the drain block.
// master = drain block, slave = FIFO/downstream environment.
interface emesh_fifo_drain_if #(
  parameter int DW = emesh_pkg::DW
);

  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_read;
  logic          emesh_wait_in;
  logic          emesh_access_out;
  logic          emesh_write_out;
  logic [1:0]    emesh_datamode_out;
  logic [3:0]    emesh_ctrlmode_out;
  logic [31:0]   emesh_dstaddr_out;
  logic [31:0]   emesh_data_out;
  logic [31:0]   emesh_srcaddr_out;
  logic [31:0]   xfer_count;

  modport master (
    input  fifo_dout,
    input  fifo_empty,
    input  emesh_wait_in,
    output fifo_read,
    output emesh_access_out,
    output emesh_write_out,
    output emesh_datamode_out,
    output emesh_ctrlmode_out,
    output emesh_dstaddr_out,
    output emesh_data_out,
    output emesh_srcaddr_out,
    output xfer_count
  );

  modport slave (
    output fifo_dout,
    output fifo_empty,
    output emesh_wait_in,
    input  fifo_read,
    input  emesh_access_out,
    input  emesh_write_out,
    input  emesh_datamode_out,
    input  emesh_ctrlmode_out,
    input  emesh_dstaddr_out,
    input  emesh_data_out,
    input  emesh_srcaddr_out,
    input  xfer_count
  );

endinterface

// File: rtl/emesh_unpack.sv
// Combinational split of a packed emesh word into its fields.
// Bit 0 of the packed word is reserved and never reaches this block.
module emesh_unpack
  import emesh_pkg::*;
#(
  parameter int DW = emesh_pkg::DW
) (
  input  logic [DW-1:1] word,
  output emesh_t        fields
);

  // slice each field out of the packed word
  always_comb begin
    fields.write    = word[WRITE_BIT];
    fields.datamode = word[DM_LSB +: 2];
    fields.ctrlmode = word[CM_LSB +: 4];
    fields.dstaddr  = word[DST_LSB +: 32];
    fields.data     = word[DATA_LSB +: 32];
    fields.srcaddr  = word[SRC_LSB +: 32];
  end

endmodule

// File: rtl/emesh_fifo_drain.sv
// Drains a FWFT FIFO onto a registered emesh bus through a one-word skid buffer.
// Define EMESH_DRAIN_CNT_EN to build the 32-bit transfer counter on xfer_count.
module emesh_fifo_drain
  import emesh_pkg::*;
#(
  parameter int DW = emesh_pkg::DW
) (
  input  logic             rd_clk,
  input  logic             reset,
  emesh_fifo_drain_if.master bus
);

  state_t        state;
  state_t        state_nx;
  logic          load_out;
  logic          load_skid;
  logic          access_q;
  logic          xfer;
  logic          rd;
  logic [DW-1:1] skid;
  logic [DW-1:1] src;
  emesh_t        src_f;
  emesh_t        out_q;
  logic          unused_bit0;

  assign unused_bit0 = bus.fifo_dout[0];

  assign xfer = access_q & ~bus.emesh_wait_in;

  // pop depends only on registered state, never on wait
  assign rd = reset & ~bus.fifo_empty & (state != TWO);
  assign bus.fifo_read = rd;

  // skid word has priority because it is older than the FIFO head
  assign src = (state == TWO) ? skid : bus.fifo_dout[DW-1:1];

  emesh_unpack #(
    .DW(DW)
  ) u_unpack (
    .word  (src),
    .fields(src_f)
  );

  // next state and register load enables
  always_comb begin
    state_nx  = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (rd) begin
          state_nx = ONE;
          load_out = 1'b1;
        end
      end
      ONE: begin
        if (xfer && rd) begin
          load_out = 1'b1;
        end else if (xfer) begin
          state_nx = EMPTY;
        end else if (rd) begin
          state_nx  = TWO;
          load_skid = 1'b1;
        end
      end
      TWO: begin
        if (xfer) begin
          state_nx = ONE;
          load_out = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // state register
  always_ff @(posedge rd_clk) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nx;
  end

  // output register, held while stalled
  always_ff @(posedge rd_clk) begin
    if (!reset) begin
      access_q <= 1'b0;
      out_q    <= '0;
    end else begin
      access_q <= (state_nx != EMPTY);
      if (load_out) out_q <= src_f;
    end
  end

  // skid register catches the word popped during a stall
  always_ff @(posedge rd_clk) begin
    if (!reset)         skid <= '0;
    else if (load_skid) skid <= bus.fifo_dout[DW-1:1];
  end

  assign bus.emesh_access_out   = access_q;
  assign bus.emesh_write_out    = out_q.write;
  assign bus.emesh_datamode_out = out_q.datamode;
  assign bus.emesh_ctrlmode_out = out_q.ctrlmode;
  assign bus.emesh_dstaddr_out  = out_q.dstaddr;
  assign bus.emesh_data_out     = out_q.data;
  assign bus.emesh_srcaddr_out  = out_q.srcaddr;

`ifdef EMESH_DRAIN_CNT_EN
  logic [31:0] cnt_q;

  // completed transfers, wrapping at 2^32
  always_ff @(posedge rd_clk) begin
    if (!reset)    cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_q + 32'd1;
  end

  assign bus.xfer_count = cnt_q;
`else
  assign bus.xfer_count = '0;
`endif

endmodule

// File: doc/emesh_fifo_drain.md
EMESH_FIFO_DRAIN -- requirements
Module: emesh_fifo_drain

Interface
REQ-001 SHALL have parameter DW, default 104, meaning packed emesh word width (fixed legal value 104).
REQ-002 SHALL have port rd_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port fifo_dout  input  DW  first-word-fall-through FIFO read data, valid whenever fifo_empty=0.
REQ-005 SHALL have port fifo_empty  input  1  FIFO holds no word.
REQ-006 SHALL have port fifo_read  output  1  pop one FIFO word this cycle.
REQ-007 SHALL have port emesh_wait_in  input  1  downstream stall.
REQ-008 SHALL have ports emesh_access_out/write_out (1), datamode_out (2), ctrlmode_out (4), dstaddr_out/data_out/srcaddr_out (32 each), all outputs, all registered.
REQ-009 SHALL have port xfer_count  output  32  count of completed emesh transfers.

Function
REQ-010 SHALL unpack the word as: bit0 reserved, bit1 write, [3:2] datamode, [7:4] ctrlmode, [39:8] dstaddr, [71:40] data, [103:72] srcaddr.
REQ-011 SHALL define a transfer as a cycle with emesh_access_out=1 and emesh_wait_in=0.
REQ-012 SHALL hold all emesh_*_out stable while emesh_access_out=1 and emesh_wait_in=1.
REQ-013 SHALL implement states EMPTY (no valid word), ONE (output register valid), TWO (output and skid registers valid).
REQ-014 SHALL drive fifo_read = ~fifo_empty & (state != TWO), with no combinational path from emesh_wait_in.
REQ-015 SHALL transition EMPTY->ONE on fifo_read, loading the output register.
REQ-016 SHALL, in ONE: transfer&read -> ONE (output reloaded); transfer&~read -> EMPTY; ~transfer&read -> TWO (skid loaded); else stay ONE.
REQ-017 SHALL, in TWO: transfer -> ONE with output loaded from skid; else stay TWO; fifo_read=0.
REQ-018 SHALL present a popped word on emesh outputs one cycle after its fifo_read, and sustain one transfer per cycle while wait=0 and FIFO non-empty.
REQ-019 SHALL drive emesh_access_out=1 exactly in states ONE and TWO.
REQ-020 SHALL never drop, duplicate or reorder words, including when wait toggles every cycle.
REQ-021 SHALL ignore fifo_dout bit0.

Reset
REQ-022 SHALL, while reset=0 at a clock edge, enter EMPTY, clear all emesh outputs and xfer_count to 0, and hold fifo_read=0.
REQ-023 SHALL discard any output/skid words on reset mid-operation; the FIFO is not popped during reset.

Configuration
REQ-024 SHALL, with EMESH_DRAIN_CNT_EN defined, increment xfer_count by 1 per transfer, wrapping 0xFFFFFFFF->0.
REQ-025 SHALL, without EMESH_DRAIN_CNT_EN, tie xfer_count to 0 and instantiate no counter logic.

Structure
REQ-026 SHALL place the DW constant, field bit-offset constants, and the state encoding in shared package emesh_pkg.
REQ-027 SHALL use combinational sub-module emesh_unpack (DW word -> emesh fields) for the output-register load path.

Verification
REQ-028 SHALL cover reset: reset=0 for 3 cycles with fifo_empty=0 -> fifo_read=0, access_out=0, xfer_count=0.
REQ-029 SHALL cover streaming: 8 words, dstaddr 0x80800000+4*i, wait=0 -> 8 consecutive transfers in order, fields match, xfer_count=8.
REQ-030 SHALL cover stall: wait=1 for 5 cycles with 4 words queued -> state TWO, fifo_read=0, outputs frozen on word0; release -> words 0..3 in order, no loss.
REQ-031 SHALL cover alternating wait (1,0,1,0...) over 16 words -> 16 transfers, order preserved, no duplicates.
REQ-032 SHALL cover mid-stream reset in TWO -> next cycle access_out=0; after release, first output is the FIFO head word, not a skid word.
REQ-033 SHALL cover counter wrap (EMESH_DRAIN_CNT_EN defined, counter forced to 0xFFFFFFFE) -> 2 transfers give 0x00000000; without macro xfer_count stays 0.
